crossbar_ctrl: RTL and testbench
================================

Name: crossbar_ctrl

Overview:
- Command sequencer directly upstream of the 8x8 ReRAM crossbar MAC array.
- Accepts row-write, MAC and form commands over a valid/ready interface.
- Generates timed bitline/wordline/selectline pulse patterns for the array, samples the array's 8-bit thresholded output after a MAC read, and returns it over a second valid/ready interface.

Parameters:
- PULSE_CYCLES, 2, cycles each set or reset phase is held (>=1)
- FORM_CYCLES, 8, cycles the form pulse is held (>=1)
- READ_CYCLES, 2, cycles the read pattern is held before xbar_out is sampled (>=2, covers the array's registered output stage)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
- cmd_op  in  2  00 write row, 01 MAC, 10 form all, 11 reserved
- cmd_row  in  3  target row for write
- cmd_data  in  8  write: weight row; MAC: input activation vector (one bit per wordline)
- bitline  out  8  to array
- wordline  out  8  to array
- selectline  out  8  to array
- wenable  out  1  high during reset/set/form phases
- form  out  1  high during form phase
- mac  out  1  high during read phase
- xbar_out  in  8  array output
- res_valid  out  1  MAC result available
- res_ready  in  1  result consumed when res_valid&res_ready at posedge
- res_data  out  8  captured MAC result
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst). Every output register is updated on posedge clk only.
- On rst: state=IDLE, all counters 0.
- Reset values: bitline/wordline/selectline=0, wenable=form=mac=0, res_valid=0, res_data=0, cmd_ready=1 from the first cycle after rst deasserts.
- rst mid-operation aborts immediately and drops any pending result.
- Line drivers are registered. All control outputs change only on posedge.
- cmd_ready = (state==IDLE). A command is accepted only in IDLE.
- States: IDLE, RST_PH, SET_PH, FORM_PH, READ_PH, GAP, RESULT.
- IDLE accept, op 00:
  - Latch row and data, go to RST_PH.
  - RST_PH, PULSE_CYCLES cycles: wordline=onehot(row), bitline=0, selectline=~data, wenable=1.
  - Then SET_PH, PULSE_CYCLES cycles: wordline=onehot(row), bitline=data, selectline=0, wenable=1.
  - Then GAP.
- IDLE accept, op 01:
  - READ_PH, READ_CYCLES cycles: wordline=data, bitline=0, selectline=0, mac=1.
  - On the posedge ending the last READ_PH cycle: res_data<=xbar_out, res_valid<=1, go to RESULT.
  - Activation vector 0x00 still runs the full sequence.
- IDLE accept, op 10:
  - FORM_PH, FORM_CYCLES cycles: wordline=0xFF, bitline=0xFF, selectline=0, wenable=1, form=1.
  - Then GAP.
- IDLE accept, op 11: accepted (handshake completes) and discarded. Stays IDLE with no line activity.
- GAP: one cycle, all lines and strobes 0. Then IDLE. Guarantees a zero cycle between consecutive array operations.
- RESULT:
  - Lines 0. res_valid and res_data held stable until res_ready.
  - On the handshake: res_valid<=0, go to GAP.
  - No command is accepted while a result is pending.
- Phase counter loads N-1 on phase entry and transitions at 0. Minimum legal N=1 gives a one-cycle phase.
- Command-to-cmd_ready recovery:
  - write row: 2*PULSE_CYCLES+1 cycles.
  - form: FORM_CYCLES+1 cycles.
  - MAC: READ_CYCLES+handshake wait+1 cycles.

Optional Feature:
- Macro: CROSSBAR_CTRL_STATS_EN.
- Defined: adds outputs write_count[15:0], mac_count[15:0], form_count[15:0].
  - Each increments by 1 on acceptance of the matching op.
  - Each saturates at 0xFFFF and clears on rst.
  - Reserved ops are not counted.
- Undefined: ports and counters absent. All other behaviour is identical.

Test Plan:
- rst held 3 cycles then released -> all line outputs 0, res_valid=0, cmd_ready=1, busy=0.
- Write row=3, data=0xA5, PULSE_CYCLES=2 ->
  - 2 cycles wl=0x08, bl=0x00, sl=0x5A, wenable=1.
  - Then 2 cycles wl=0x08, bl=0xA5, sl=0x00.
  - Then 1 GAP cycle of all zero.
  - cmd_ready returns after 5 cycles.
- Form -> 8 cycles wl=0xFF, bl=0xFF, sl=0x00, form=1, wenable=1. Then GAP, then IDLE.
- MAC data=0x0F, xbar_out forced to 0x3C on the last read cycle, res_ready held 0 for 4 cycles ->
  - wl=0x0F, mac=1 for 2 cycles.
  - res_valid=1 with res_data=0x3C held stable.
  - cmd_ready=0 until the handshake plus the GAP cycle.
- cmd_op=11 with cmd_valid=1 -> accepted in 1 cycle, lines stay 0, busy stays 0. With STATS_EN, no counter changes.
- rst asserted in the 2nd SET_PH cycle of a write -> next cycle all lines 0, state IDLE, cmd_ready=1, no GAP. Subsequent MAC completes normally.

Source files
------------

// File: rtl/crossbar_ctrl.sv
// Command sequencer for the 8x8 ReRAM crossbar: row write, MAC read and form pulse timing.
// Optional per-op acceptance counters are compiled in with CROSSBAR_CTRL_STATS_EN.
module crossbar_ctrl #(
   parameter int PULSE_CYCLES = 2,
   parameter int FORM_CYCLES  = 8,
   parameter int READ_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [2:0] cmd_row,
   input  logic [7:0] cmd_data,
   output logic [7:0] bitline,
   output logic [7:0] wordline,
   output logic [7:0] selectline,
   output logic       wenable,
   output logic       form,
   output logic       mac,
   input  logic [7:0] xbar_out,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic       busy
`ifdef CROSSBAR_CTRL_STATS_EN
   ,
   output logic [15:0] write_count,
   output logic [15:0] mac_count,
   output logic [15:0] form_count
`endif
);

   localparam int MAX_A = (PULSE_CYCLES > FORM_CYCLES) ? PULSE_CYCLES : FORM_CYCLES;
   localparam int MAX_C = (MAX_A > READ_CYCLES) ? MAX_A : READ_CYCLES;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_MAC   = 2'b01;
   localparam logic [1:0] OP_FORM  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RST_PH,
      SET_PH,
      FORM_PH,
      READ_PH,
      GAP,
      RESULT
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    row_q, row_nx;
   logic [7:0]    data_q, data_nx;
   logic          res_valid_nx;
   logic [7:0]    res_data_nx;
   logic [7:0]    bitline_nx, wordline_nx, selectline_nx;
   logic          wenable_nx, form_nx, mac_nx;
   logic          accept;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      row_nx       = row_q;
      data_nx      = data_q;
      res_valid_nx = res_valid;
      res_data_nx  = res_data;

      case (state)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_WRITE: begin
                     state_nx = RST_PH;
                     cnt_nx   = CW'(PULSE_CYCLES - 1);
                     row_nx   = cmd_row;
                     data_nx  = cmd_data;
                  end
                  OP_MAC: begin
                     state_nx = READ_PH;
                     cnt_nx   = CW'(READ_CYCLES - 1);
                     data_nx  = cmd_data;
                  end
                  OP_FORM: begin
                     state_nx = FORM_PH;
                     cnt_nx   = CW'(FORM_CYCLES - 1);
                  end
                  default: state_nx = IDLE;
               endcase
            end
         end
         RST_PH: begin
            if (cnt == '0) begin
               state_nx = SET_PH;
               cnt_nx   = CW'(PULSE_CYCLES - 1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         SET_PH: begin
            if (cnt == '0) state_nx = GAP;
            else           cnt_nx   = cnt - CW'(1);
         end
         FORM_PH: begin
            if (cnt == '0) state_nx = GAP;
            else           cnt_nx   = cnt - CW'(1);
         end
         READ_PH: begin
            // xbar_out is captured on the edge that ends the final read cycle
            if (cnt == '0) begin
               state_nx     = RESULT;
               res_valid_nx = 1'b1;
               res_data_nx  = xbar_out;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         GAP: state_nx = IDLE;
         RESULT: begin
            if (res_ready) begin
               state_nx     = GAP;
               res_valid_nx = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Line drivers are registered, so decode the pattern for the state being entered.
   always_comb begin
      bitline_nx    = 8'h00;
      wordline_nx   = 8'h00;
      selectline_nx = 8'h00;
      wenable_nx    = 1'b0;
      form_nx       = 1'b0;
      mac_nx        = 1'b0;
      case (state_nx)
         RST_PH: begin
            wordline_nx   = 8'b1 << row_nx;
            selectline_nx = ~data_nx;
            wenable_nx    = 1'b1;
         end
         SET_PH: begin
            wordline_nx = 8'b1 << row_nx;
            bitline_nx  = data_nx;
            wenable_nx  = 1'b1;
         end
         FORM_PH: begin
            wordline_nx = 8'hFF;
            bitline_nx  = 8'hFF;
            wenable_nx  = 1'b1;
            form_nx     = 1'b1;
         end
         READ_PH: begin
            wordline_nx = data_nx;
            mac_nx      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         row_q      <= '0;
         data_q     <= '0;
         res_valid  <= 1'b0;
         res_data   <= 8'h00;
         bitline    <= 8'h00;
         wordline   <= 8'h00;
         selectline <= 8'h00;
         wenable    <= 1'b0;
         form       <= 1'b0;
         mac        <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         row_q      <= row_nx;
         data_q     <= data_nx;
         res_valid  <= res_valid_nx;
         res_data   <= res_data_nx;
         bitline    <= bitline_nx;
         wordline   <= wordline_nx;
         selectline <= selectline_nx;
         wenable    <= wenable_nx;
         form       <= form_nx;
         mac        <= mac_nx;
      end
   end

`ifdef CROSSBAR_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         write_count <= 16'h0000;
         mac_count   <= 16'h0000;
         form_count  <= 16'h0000;
      end else if (accept) begin
         case (cmd_op)
            OP_WRITE: if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
            OP_MAC:   if (mac_count   != 16'hFFFF) mac_count   <= mac_count + 16'd1;
            OP_FORM:  if (form_count  != 16'hFFFF) form_count  <= form_count + 16'd1;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_crossbar_ctrl.sv
// Directed bench for crossbar_ctrl with default parameters (PULSE=2, FORM=8, READ=2).
module tb_crossbar_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [2:0] cmd_row;
   logic [7:0] cmd_data;
   logic [7:0] xbar_out;
   logic       res_ready;
   wire        cmd_ready;
   wire  [7:0] bitline, wordline, selectline, res_data;
   wire        wenable, form, mac, res_valid, busy;
`ifdef CROSSBAR_CTRL_STATS_EN
   wire [15:0] write_count, mac_count, form_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // {wordline, bitline, selectline, wenable, form, mac}
   wire [26:0] lines = {wordline, bitline, selectline, wenable, form, mac};

   always #5 clk = ~clk;

   crossbar_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_row    (cmd_row),
      .cmd_data   (cmd_data),
      .bitline    (bitline),
      .wordline   (wordline),
      .selectline (selectline),
      .wenable    (wenable),
      .form       (form),
      .mac        (mac),
      .xbar_out   (xbar_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .busy       (busy)
`ifdef CROSSBAR_CTRL_STATS_EN
      ,
      .write_count(write_count),
      .mac_count  (mac_count),
      .form_count (form_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one command for a single cycle; returns just after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [2:0] row, input logic [7:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_row   = row;
      cmd_data  = data;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_row   = 3'd0;
      cmd_data  = 8'h00;
      xbar_out  = 8'h00;
      res_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (lines !== 27'h0) begin
         n_fail++; $display("FAIL reset_lines got %h exp %h", lines, 27'h0);
      end
      n_checks++;
      if ({res_valid, res_data} !== 9'h000) begin
         n_fail++; $display("FAIL reset_result got %h exp %h", {res_valid, res_data}, 9'h000);
      end
      n_checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_fail++; $display("FAIL reset_ready_busy got %b exp %b", {cmd_ready, busy}, 2'b10);
      end
   endtask

   task automatic test_write();
      logic [26:0] exp_lines;
      logic        exp_rdy;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL write_pre_ready got %b exp 1", cmd_ready);
      end
      n_checks++;
      issue(2'b00, 3'd3, 8'hA5);
      for (int k = 0; k < 6; k++) begin
         if (k < 2)      exp_lines = {8'h08, 8'h00, 8'h5A, 3'b100};
         else if (k < 4) exp_lines = {8'h08, 8'hA5, 8'h00, 3'b100};
         else            exp_lines = 27'h0;
         exp_rdy = (k == 5);
         n_checks++;
         if (lines !== exp_lines) begin
            n_fail++; $display("FAIL write_lines k=%0d got %h exp %h", k, lines, exp_lines);
         end
         n_checks++;
         if (cmd_ready !== exp_rdy) begin
            n_fail++; $display("FAIL write_ready k=%0d got %b exp %b", k, cmd_ready, exp_rdy);
         end
         tick();
      end
   endtask

   task automatic test_form();
      logic [26:0] exp_lines;
      issue(2'b10, 3'd0, 8'h00);
      for (int k = 0; k < 10; k++) begin
         exp_lines = (k < 8) ? {8'hFF, 8'hFF, 8'h00, 3'b110} : 27'h0;
         n_checks++;
         if (lines !== exp_lines) begin
            n_fail++; $display("FAIL form_lines k=%0d got %h exp %h", k, lines, exp_lines);
         end
         n_checks++;
         if ({cmd_ready, busy} !== ((k == 9) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL form_ready_busy k=%0d got %b", k, {cmd_ready, busy});
         end
         tick();
      end
   endtask

   task automatic test_mac();
      logic [26:0] exp_lines;
      xbar_out = 8'h00;
      issue(2'b01, 3'd0, 8'h0F);
      for (int k = 0; k < 8; k++) begin
         exp_lines = (k < 2) ? {8'h0F, 8'h00, 8'h00, 3'b001} : 27'h0;
         if (k == 1) xbar_out = 8'h3C;
         if (k == 2) xbar_out = 8'hFF;
         res_ready = (k == 5);
         n_checks++;
         if (lines !== exp_lines) begin
            n_fail++; $display("FAIL mac_lines k=%0d got %h exp %h", k, lines, exp_lines);
         end
         n_checks++;
         if (cmd_ready !== (k == 7)) begin
            n_fail++; $display("FAIL mac_ready k=%0d got %b exp %b", k, cmd_ready, (k == 7));
         end
         if (k >= 2) begin
            n_checks++;
            if ({res_valid, res_data} !== {(k < 6), 8'h3C}) begin
               n_fail++; $display("FAIL mac_result k=%0d got %h exp %h", k, {res_valid, res_data}, {(k < 6), 8'h3C});
            end
         end
         tick();
      end
      res_ready = 1'b0;
   endtask

   task automatic test_reserved();
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_data  = 8'hFF;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL rsvd_offer_ready got %b exp 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if ({lines, cmd_ready, busy, res_valid} !== {27'h0, 3'b100}) begin
            n_fail++; $display("FAIL rsvd_idle k=%0d got %h exp %h", k, {lines, cmd_ready, busy, res_valid}, {27'h0, 3'b100});
         end
         tick();
      end
`ifdef CROSSBAR_CTRL_STATS_EN
      n_checks++;
      if ({write_count, mac_count, form_count} !== {16'd1, 16'd1, 16'd1}) begin
         n_fail++; $display("FAIL rsvd_stats got %h exp %h", {write_count, mac_count, form_count}, {16'd1, 16'd1, 16'd1});
      end
`endif
   endtask

   task automatic test_reset_mid();
      issue(2'b00, 3'd1, 8'h33);
      repeat (3) tick();
      n_checks++;
      if (lines !== {8'h02, 8'h33, 8'h00, 3'b100}) begin
         n_fail++; $display("FAIL abort_set2 got %h exp %h", lines, {8'h02, 8'h33, 8'h00, 3'b100});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({lines, cmd_ready, busy} !== {27'h0, 2'b10}) begin
         n_fail++; $display("FAIL abort_idle got %h exp %h", {lines, cmd_ready, busy}, {27'h0, 2'b10});
      end
      tick();
      n_checks++;
      if ({lines, cmd_ready, busy} !== {27'h0, 2'b10}) begin
         n_fail++; $display("FAIL abort_no_gap got %h exp %h", {lines, cmd_ready, busy}, {27'h0, 2'b10});
      end
      // MAC after the abort, with an all-zero activation vector, result consumed at once
      xbar_out = 8'h00;
      issue(2'b01, 3'd0, 8'h00);
      n_checks++;
      if (lines !== {8'h00, 8'h00, 8'h00, 3'b001}) begin
         n_fail++; $display("FAIL mac0_read got %h exp %h", lines, {8'h00, 8'h00, 8'h00, 3'b001});
      end
      tick();
      xbar_out = 8'h5A;
      tick();
      res_ready = 1'b1;
      n_checks++;
      if ({res_valid, res_data, lines} !== {1'b1, 8'h5A, 27'h0}) begin
         n_fail++; $display("FAIL mac0_result got %h exp %h", {res_valid, res_data, lines}, {1'b1, 8'h5A, 27'h0});
      end
      tick();
      res_ready = 1'b0;
      tick();
      n_checks++;
      if ({cmd_ready, res_valid} !== 2'b10) begin
         n_fail++; $display("FAIL mac0_recover got %b exp 10", {cmd_ready, res_valid});
      end
      // reset while a result is pending drops it
      issue(2'b01, 3'd0, 8'hF0);
      xbar_out = 8'h77;
      repeat (2) tick();
      n_checks++;
      if (res_valid !== 1'b1) begin
         n_fail++; $display("FAIL pend_valid got %b exp 1", res_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({res_valid, res_data, cmd_ready} !== {1'b0, 8'h00, 1'b1}) begin
         n_fail++; $display("FAIL pend_drop got %h exp %h", {res_valid, res_data, cmd_ready}, {1'b0, 8'h00, 1'b1});
      end
`ifdef CROSSBAR_CTRL_STATS_EN
      n_checks++;
      if ({write_count, mac_count, form_count} !== 48'h0) begin
         n_fail++; $display("FAIL stats_clear got %h exp 0", {write_count, mac_count, form_count});
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_form();
      test_mac();
      test_reserved();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
